// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared widths and sequencer state encoding for the multdiv unit
package multdiv_pkg;
  localparam int MULT_WIDTH = 32;
  localparam int PROD_WIDTH = 2*MULT_WIDTH+1;
  localparam int CNT_WIDTH = $clog2(MULT_WIDTH)+1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/booth_step.sv
// booth_step: one radix-2 Booth step, {P, M} -> next P (add/sub M on the upper half, then asr)
module booth_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH:0] p,
  input  logic [WIDTH-1:0] m,
  output logic [2*WIDTH:0] p_next
);
  logic [WIDTH:0] a, me, a_n;
  // add/sub in WIDTH+1 bits so M = -2^(WIDTH-1) cannot overflow, then shift the new sign in
  always_comb begin
    a = {p[2*WIDTH], p[2*WIDTH:WIDTH+1]};
    me = {m[WIDTH-1], m};
    a_n = (p[1:0] == 2'b01) ? a + me : (p[1:0] == 2'b10) ? a - me : a;
    p_next = {a_n, p[WIDTH:1]};
  end
endmodule

// File: rtl/booth_mult_seq.sv
// booth_mult_seq: iterative radix-2 signed Booth multiplier sequencer; MULT_EARLY_ZERO_EN enables zero-operand shortcut
module booth_mult_seq
  import multdiv_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic             clock,
  input  logic             ctrl_reset,
  input  logic             ctrl_MULT,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);
  localparam int CW = $clog2(WIDTH)+1;
  state_t state;
  logic [2*WIDTH:0] p, p_next;
  logic [WIDTH-1:0] m;
  logic [CW-1:0] cnt;
  logic zero_start;
`ifdef MULT_EARLY_ZERO_EN
  assign zero_start = (data_operandA == '0) || (data_operandB == '0);
`else
  assign zero_start = 1'b0;
`endif
  booth_step #(.WIDTH(WIDTH)) u_step (.p(p), .m(m), .p_next(p_next));
  // FSM, counter and P/M registers; start may restart mid-run, reset overrides everything
  always_ff @(posedge clock) begin
    if (!ctrl_reset) begin
      state <= IDLE;
      p <= '0;
      m <= '0;
      cnt <= '0;
      data_resultRDY <= 1'b0;
    end else if (ctrl_MULT) begin
      m <= data_operandA;
      p <= zero_start ? '0 : {{WIDTH{1'b0}}, data_operandB, 1'b0};
      cnt <= '0;
      state <= zero_start ? DONE : RUN;
      data_resultRDY <= zero_start;
    end else if (state == RUN) begin
      p <= p_next;
      cnt <= cnt + CW'(1);
      if (cnt == CW'(WIDTH-1)) begin
        state <= DONE;
        data_resultRDY <= 1'b1;
      end
    end
  end
  // outputs read straight from the product register, gated until the result is ready
  always_comb begin
    data_result = data_resultRDY ? p[WIDTH:1] : '0;
    data_exception = data_resultRDY && (p[2*WIDTH:WIDTH+1] != {WIDTH{p[WIDTH]}});
  end
endmodule

// File: tb/tb_booth_mult_seq.sv
// tb_booth_mult_seq: directed table-driven check of booth_mult_seq plus restart/reset sequences
module tb_booth_mult_seq;
  logic clk = 1'b0;
  logic rst_n, mult;
  logic [31:0] opa, opb, res;
  logic exc, rdy;
  int n_chk = 0, n_fail = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        e;
  } vec_t;
  vec_t vecs[11];

`ifdef MULT_EARLY_ZERO_EN
  localparam int ZLAT = 0;
`else
  localparam int ZLAT = 32;
`endif

  booth_mult_seq dut (
    .clock(clk), .ctrl_reset(rst_n), .ctrl_MULT(mult),
    .data_operandA(opa), .data_operandB(opb),
    .data_result(res), .data_exception(exc), .data_resultRDY(rdy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic start(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    mult = 1'b1; opa = a; opb = b;
    @(negedge clk);
    mult = 1'b0;
  endtask

  task automatic wait_rdy(input string nm, input int lat);
    int n = 0;
    while (!rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " latency"}, n, lat);
  endtask

  task automatic run(input string nm, input logic [31:0] a, input logic [31:0] b,
                     input int lat, input logic [31:0] r, input logic e);
    start(a, b);
    chk({nm, " rdy_after_start"}, {31'b0, rdy}, {31'b0, lat == 0});
    if (lat != 0) chk({nm, " gated_result"}, res, 32'h0);
    wait_rdy(nm, lat);
    chk({nm, " result"}, res, r);
    chk({nm, " exception"}, {31'b0, exc}, {31'b0, e});
    repeat (3) @(negedge clk);
    chk({nm, " hold"}, {res[30:0], exc}, {r[30:0], e});
  endtask

  initial begin
    vecs[0]  = '{32'd3,        32'd4,        32'd12,         1'b0};
    vecs[1]  = '{-32'sd7,      32'd6,        32'hFFFFFFD6,   1'b0};
    vecs[2]  = '{32'h80000000, 32'h80000000, 32'h0,          1'b1};
    vecs[3]  = '{32'h00010000, 32'h00010000, 32'h0,          1'b1};
    vecs[4]  = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000001,   1'b0};
    vecs[5]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,          1'b0};
    vecs[6]  = '{32'h0000FFFF, 32'h0000FFFF, 32'hFFFE0001,   1'b1};
    vecs[7]  = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h1,          1'b1};
    vecs[8]  = '{-32'sd5,      -32'sd3,      32'd15,         1'b0};
    vecs[9]  = '{32'h80000000, 32'h1,        32'h80000000,   1'b0};
    vecs[10] = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000,   1'b1};

    rst_n = 1'b0; mult = 1'b0; opa = '0; opb = '0;
    repeat (3) @(negedge clk);
    chk("reset rdy", {31'b0, rdy}, 32'h0);
    chk("reset result", res, 32'h0);
    chk("reset exception", {31'b0, exc}, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++)
      run($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, 32, vecs[i].r, vecs[i].e);

    run("zero_a", 32'h0, 32'd12345, ZLAT, 32'h0, 1'b0);

    start(32'd5, 32'd5);
    repeat (9) @(negedge clk);
    mult = 1'b1; opa = 32'd2; opb = 32'd9;
    @(negedge clk);
    mult = 1'b0;
    chk("restart rdy_low", {31'b0, rdy}, 32'h0);
    wait_rdy("restart", 32);
    chk("restart result", res, 32'd18);
    chk("restart exception", {31'b0, exc}, 32'h0);

    start(32'd3, 32'd4);
    repeat (14) @(negedge clk);
    rst_n = 1'b0; mult = 1'b1; opa = 32'd7; opb = 32'd7;
    @(negedge clk);
    chk("midrun_reset rdy", {31'b0, rdy}, 32'h0);
    chk("midrun_reset result", res, 32'h0);
    @(negedge clk);
    rst_n = 1'b1; mult = 1'b0;
    repeat (40) @(negedge clk);
    chk("reset_ignores_start rdy", {31'b0, rdy}, 32'h0);

    run("after_reset", 32'd11, -32'sd3, 32, -32'sd33, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
